// File: rtl/tri_bus_pkg.sv
// Shared definitions for the two-source tri-state bus arbiter:
// FSM state encoding, mux select constants and the round-robin pick helper.
package tri_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    TURN = 2'd3
  } arb_state_t;

  // Downstream tri-state mux select encoding
  localparam logic SEL_SRC0 = 1'b0;
  localparam logic SEL_SRC1 = 1'b1;

  // Chooses the next owner among the current requesters. last is the
  // source served most recently; on a tie the other source wins.
  // The result is meaningful only when at least one request is high.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    logic pick;
    pick = SEL_SRC0;
    if (r1 && !r0) begin
      pick = SEL_SRC1;
    end else if (r0 && r1 && (last == SEL_SRC0)) begin
      pick = SEL_SRC1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/tri_bus_hold_timer.sv
// Grant hold timer for the tri-state bus arbiter. Cleared when a new grant
// starts, advanced on every owned cycle, and flags the final allowed grant
// cycle so the arbiter releases the bus at the end of it.
module tri_bus_hold_timer
  import tri_bus_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_reg;

  // Count owned cycles since the grant started; saturate on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (count && (cnt_reg != LAST_CNT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // The current owned cycle is the MAX_HOLD-th one
  assign expire = (cnt_reg == LAST_CNT);

endmodule

// File: rtl/tri_bus_arbiter.sv
// Two-source round-robin arbiter driving a downstream tri-state bus mux.
// Every ownership change passes through a one-cycle TURN gap with the bus
// released, so the two drivers can never overlap. All outputs registered.
// Optional build macro: TRI_BUS_TIMEOUT_EN -- limits each grant to MAX_HOLD
// cycles and then forces a TURN even if the owner still requests.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             oe,
  output logic [WIDTH-1:0] bus_data,
  output logic             bus_valid
);

  arb_state_t       state_reg;
  logic             gnt0_reg;
  logic             gnt1_reg;
  logic             sel_reg;
  logic             oe_reg;
  logic             last_reg;
  logic [WIDTH-1:0] bus_data_reg;
  logic             bus_valid_reg;

  logic             arb_any;
  logic             arb_pick;
  logic             hold_expire;

  // Arbitration decision taken whenever nobody owns the bus (IDLE or TURN)
  always_comb begin
    arb_any  = req0 | req1;
    arb_pick = rr_pick(req0, req1, last_reg);
  end

`ifdef TRI_BUS_TIMEOUT_EN
  logic owner_state;
  logic timer_load;

  assign owner_state = (state_reg == OWN0) || (state_reg == OWN1);
  assign timer_load  = !owner_state && arb_any;

  tri_bus_hold_timer #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .count  (owner_state),
    .expire (hold_expire)
  );
`else
  // Ownership lasts until the owner releases its request
  assign hold_expire = 1'b0;
`endif

  // Ownership FSM with registered grant, select and drive-enable outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      gnt0_reg  <= 1'b0;
      gnt1_reg  <= 1'b0;
      sel_reg   <= SEL_SRC0;
      oe_reg    <= 1'b0;
      // Pretend source 1 was served last so source 0 wins the first tie
      last_reg  <= SEL_SRC1;
    end else begin
      case (state_reg)
        IDLE, TURN: begin
          if (arb_any) begin
            if (arb_pick == SEL_SRC1) begin
              state_reg <= OWN1;
              gnt0_reg  <= 1'b0;
              gnt1_reg  <= 1'b1;
              sel_reg   <= SEL_SRC1;
            end else begin
              state_reg <= OWN0;
              gnt0_reg  <= 1'b1;
              gnt1_reg  <= 1'b0;
              sel_reg   <= SEL_SRC0;
            end
            oe_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
            gnt0_reg  <= 1'b0;
            gnt1_reg  <= 1'b0;
            oe_reg    <= 1'b0;
          end
        end

        OWN0: begin
          if (!req0 || hold_expire) begin
            state_reg <= TURN;
            gnt0_reg  <= 1'b0;
            gnt1_reg  <= 1'b0;
            oe_reg    <= 1'b0;
            last_reg  <= SEL_SRC0;
          end else begin
            gnt0_reg  <= 1'b1;
            gnt1_reg  <= 1'b0;
            oe_reg    <= 1'b1;
          end
        end

        OWN1: begin
          if (!req1 || hold_expire) begin
            state_reg <= TURN;
            gnt0_reg  <= 1'b0;
            gnt1_reg  <= 1'b0;
            oe_reg    <= 1'b0;
            last_reg  <= SEL_SRC1;
          end else begin
            gnt0_reg  <= 1'b0;
            gnt1_reg  <= 1'b1;
            oe_reg    <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          gnt0_reg  <= 1'b0;
          gnt1_reg  <= 1'b0;
          oe_reg    <= 1'b0;
        end
      endcase
    end
  end

  // Capture the driven source's data while the bus is enabled; hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_data_reg  <= '0;
      bus_valid_reg <= 1'b0;
    end else begin
      bus_valid_reg <= oe_reg;
      if (oe_reg) begin
        bus_data_reg <= (sel_reg == SEL_SRC1) ? data1 : data0;
      end
    end
  end

  assign gnt0      = gnt0_reg;
  assign gnt1      = gnt1_reg;
  assign sel       = sel_reg;
  assign oe        = oe_reg;
  assign bus_data  = bus_data_reg;
  assign bus_valid = bus_valid_reg;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench for tri_bus_arbiter with a transaction-level model of
// bus ownership (current owner, last served, grant age).
module tb_tri_bus_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;
`ifdef TRI_BUS_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic             oe;
  logic [WIDTH-1:0] bus_data;
  logic             bus_valid;
  logic [12:0]      obs;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int               m_owner;  // -1 = nobody owns the bus
  int               m_held;   // grant cycles of the current owner so far
  bit               m_last;   // source served most recently
  bit               m_sel;
  logic [WIDTH-1:0] m_bus;
  bit               m_bv;

  tri_bus_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .oe        (oe),
    .bus_data  (bus_data),
    .bus_valid (bus_valid)
  );

  always #5 clk = ~clk;

  assign obs = {gnt0, gnt1, sel, oe, bus_valid, bus_data};

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 1'b1;
    m_sel   = 1'b0;
    m_bus   = '0;
    m_bv    = 1'b0;
  endfunction

  function automatic logic [12:0] exp_vec();
    return {m_owner == 0, m_owner == 1, m_sel, m_owner >= 0, m_bv, m_bus};
  endfunction

  // One rising edge of the specified behaviour, using the current inputs
  function automatic void model_edge();
    bit owner_req;
    bit was_oe;
    was_oe = (m_owner >= 0);
    m_bv = was_oe;
    if (was_oe) m_bus = m_sel ? data1 : data0;
    if (m_owner >= 0) begin
      owner_req = (m_owner == 0) ? req0 : req1;
      if (!owner_req || (TIMEOUT_EN && m_held >= MAX_HOLD)) begin
        m_last  = m_owner[0];
        m_owner = -1;   // one cycle with nobody driving
      end else begin
        m_held++;
      end
    end else begin
      if (req0 && req1)  m_owner = m_last ? 0 : 1;
      else if (req0)     m_owner = 0;
      else if (req1)     m_owner = 1;
      if (m_owner >= 0) begin
        m_held = 1;
        m_sel  = m_owner[0];
      end
    end
  endfunction

  // Drive one cycle of inputs (called at a falling edge), return at next falling edge
  task automatic advance(input logic r0, input logic r1,
                         input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    req0  = r0;
    req1  = r1;
    data0 = d0;
    data1 = d1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = '0;
    data1 = '0;
    model_reset();
    @(negedge clk);
    total++;
    if (obs !== 13'b0) begin
      bad++;
      $display("FAIL reset_state obs=%h exp=%h", obs, 13'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance(1'b1, 1'b0, 8'h3C, 8'hC3);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL reset_own0 obs=%h exp=%h", obs, exp_vec());
      end
    end
    $display("reset: in OWN0 gnt0=%b bus_data=%h bus_valid=%b", gnt0, bus_data, bus_valid);
    // Asynchronous reset in the middle of the cycle while req0 stays high
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if ({gnt0, gnt1, oe, bus_valid, bus_data} !== 12'b0) begin
      bad++;
      $display("FAIL reset_mid_grant obs=%h exp=%h", {gnt0, gnt1, oe, bus_valid, bus_data}, 12'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    advance(1'b1, 1'b0, 8'h11, 8'h22);
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL reset_first_arb obs=%h exp=%h", obs, exp_vec());
    end
    for (int i = 0; i < 2; i++) begin
      advance(1'b0, 1'b0, 8'h11, 8'h22);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL reset_release obs=%h exp=%h", obs, exp_vec());
      end
    end
    $display("reset: after release gnt0=%b gnt1=%b oe=%b", gnt0, gnt1, oe);
  endtask

  task automatic test_single_grant();
    advance(1'b1, 1'b0, 8'hA5, 8'h5A);
    total++;
    if ({gnt0, gnt1, sel, oe} !== 4'b1001) begin
      bad++;
      $display("FAIL grant_latency obs=%b exp=%b", {gnt0, gnt1, sel, oe}, 4'b1001);
    end
    advance(1'b1, 1'b0, 8'hA5, 8'h5A);
    total++;
    if ({bus_valid, bus_data} !== {1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL bus_capture obs=%h exp=%h", {bus_valid, bus_data}, {1'b1, 8'hA5});
    end
    $display("single: gnt0=%b sel=%b oe=%b bus_data=%h bus_valid=%b", gnt0, sel, oe, bus_data, bus_valid);
    for (int i = 0; i < 3; i++) begin
      advance(1'b0, 1'b0, 8'h00, 8'h00);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL single_release obs=%h exp=%h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_both_turn();
    apply_reset();
    advance(1'b1, 1'b1, 8'h10, 8'h20);
    total++;
    if ({gnt0, gnt1, sel, oe} !== 4'b1001) begin
      bad++;
      $display("FAIL tie_first_gnt0 obs=%b exp=%b", {gnt0, gnt1, sel, oe}, 4'b1001);
    end
    advance(1'b1, 1'b1, 8'h11, 8'h21);
    advance(1'b0, 1'b1, 8'h12, 8'h22);
    total++;
    if ({gnt0, gnt1, sel, oe} !== 4'b0000) begin
      bad++;
      $display("FAIL turn_cycle obs=%b exp=%b", {gnt0, gnt1, sel, oe}, 4'b0000);
    end
    advance(1'b0, 1'b1, 8'h13, 8'h23);
    total++;
    if ({gnt0, gnt1, sel, oe} !== 4'b0111) begin
      bad++;
      $display("FAIL handover_gnt1 obs=%b exp=%b", {gnt0, gnt1, sel, oe}, 4'b0111);
    end
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL handover_model obs=%h exp=%h", obs, exp_vec());
    end
    $display("both: handover gnt1=%b sel=%b bus_data=%h", gnt1, sel, bus_data);
    advance(1'b0, 1'b0, 8'h00, 8'h00);
    advance(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_hold();
    int g0_seen;
    int g1_seen;
    int g0_exp;
    int g1_exp;
    g0_seen = 0; g1_seen = 0; g0_exp = 0; g1_exp = 0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      advance(1'b1, 1'b1, 8'($urandom), 8'($urandom));
      g0_seen += int'(gnt0);
      g1_seen += int'(gnt1);
      g0_exp  += (m_owner == 0) ? 1 : 0;
      g1_exp  += (m_owner == 1) ? 1 : 0;
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL hold_cycle%0d obs=%h exp=%h", i, obs, exp_vec());
      end
    end
    total++;
    if (g0_seen != g0_exp || g1_seen != g1_exp) begin
      bad++;
      $display("FAIL hold_counts obs=%0d/%0d exp=%0d/%0d", g0_seen, g1_seen, g0_exp, g1_exp);
    end
    $display("hold: 40 cycles gnt0_cycles=%0d gnt1_cycles=%0d", g0_seen, g1_seen);
    advance(1'b0, 1'b0, 8'h00, 8'h00);
    advance(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    logic r0;
    logic r1;
    logic [1:0] prev_g;
    int errs_before;
    apply_reset();
    r0 = 1'b0; r1 = 1'b0; prev_g = 2'b00;
    errs_before = bad;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) r0 = ~r0;
      if ($urandom_range(3) == 0) r1 = ~r1;
      advance(r0, r1, 8'($urandom), 8'($urandom));
      total++;
      if (gnt0 && gnt1) begin
        bad++;
        $display("FAIL rand_exclusive cyc=%0d obs=%b%b exp=not_both", i, gnt0, gnt1);
      end
      total++;
      if (oe !== (gnt0 | gnt1)) begin
        bad++;
        $display("FAIL rand_oe cyc=%0d obs=%b exp=%b", i, oe, gnt0 | gnt1);
      end
      total++;
      if ((prev_g == 2'b10 && {gnt0, gnt1} == 2'b01) || (prev_g == 2'b01 && {gnt0, gnt1} == 2'b10)) begin
        bad++;
        $display("FAIL rand_turn cyc=%0d obs=%b->%b exp=gap", i, prev_g, {gnt0, gnt1});
      end
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL rand_model cyc=%0d obs=%h exp=%h", i, obs, exp_vec());
      end
      prev_g = {gnt0, gnt1};
    end
    $display("random: 1000 cycles, new errors=%0d", bad - errs_before);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = '0;
    data1 = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_grant();
    test_both_turn();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
